// File: rtl/instr_encoder_if.sv
// Field-bundle in / encoded-word out stream bundle for the instruction encoder.
// master: host side driving fields and taking words; slave: the encoder.
interface instr_encoder_if #(
  parameter int AW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [3:0]    in_opcode;
  logic [3:0]    in_rs1;
  logic [3:0]    in_rs2;
  logic [3:0]    in_rd;
  logic [1:0]    in_funct2;
  logic [2:0]    in_alu_type;
  logic [10:0]   in_addr11;
  logic [7:0]    in_addr8;
  logic          out_valid;
  logic          out_ready;
  logic [18:0]   out_instr;
  logic [AW-1:0] out_addr;

  modport master (
    output in_valid, in_last, in_opcode,
    output in_rs1, in_rs2, in_rd,
    output in_funct2, in_alu_type,
    output in_addr11, in_addr8,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );

  modport slave (
    input  in_valid, in_last, in_opcode,
    input  in_rs1, in_rs2, in_rd,
    input  in_funct2, in_alu_type,
    input  in_addr11, in_addr8,
    output in_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded fields into 19-bit IMEM words with auto-incrementing address.
// Optional FIELD_CHECK_EN flags unencodable or inconsistent field bundles.
module instr_encoder #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  instr_encoder_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          field_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic          ov_q;
  logic [18:0]   instr_q;
  logic [AW-1:0] addr_q;
  logic [18:0]   enc;
  logic          in_fire;
  logic          at_top;

  logic [3:0] op;
  logic op_r, op_i, op_j, op_b;
  logic op_ld, op_m, op_ret;

  assign op     = bus.in_opcode;
  assign op_r   = (op == 4'd0) || (op == 4'd1)
                || (op[3:2] == 2'b11);
  assign op_i   = (op == 4'd2);
  assign op_j   = (op == 4'd3) || (op == 4'd7);
  assign op_b   = (op == 4'd4);
  assign op_ld  = (op == 4'd5);
  assign op_m   = (op == 4'd6) || (op == 4'd9)
                || (op == 4'd10) || (op == 4'd11);
  assign op_ret = (op == 4'd8);

  always_comb begin
    enc = '0;
    unique case (1'b1)
      op_r:   enc = {op, bus.in_rs1, bus.in_rs2,
                     bus.in_rd, bus.in_alu_type};
      op_i:   enc = {op, bus.in_rs1, bus.in_funct2,
                     2'b00, bus.in_rd, 3'b000};
      op_j:   enc = {op, 4'b0000, bus.in_addr11};
      // branch: rs2[0] doubles as address bit 7
      op_b:   enc = {op, bus.in_rs1, bus.in_rs2,
                     bus.in_addr8[6:0]};
      op_ld:  enc = {op, bus.in_rd, 3'b000,
                     bus.in_addr8};
      op_m:   enc = {op, bus.in_rs1, 3'b000,
                     bus.in_addr8};
      op_ret: enc = {op, 15'd0};
      default: enc = '0;
    endcase
  end

  assign at_top       = (wr_ptr == {AW{1'b1}});
  assign bus.in_ready = (state == RUN)
                      && (!ov_q || bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (in_fire && (bus.in_last || at_top))
               state_nxt = DRAIN;
      DRAIN: if (!ov_q || bus.out_ready)
               state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      ov_q     <= 1'b0;
      instr_q  <= '0;
      addr_q   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        wr_ptr   <= base_addr;
        overflow <= 1'b0;
      end
      if (in_fire) begin
        instr_q <= enc;
        addr_q  <= wr_ptr;
        ov_q    <= 1'b1;
        // pointer parks at the top word
        if (!at_top)
          wr_ptr <= wr_ptr + 1'b1;
        else if (!bus.in_last)
          overflow <= 1'b1;
      end else if (bus.out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);

`ifdef FIELD_CHECK_EN
  logic bad;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      op_r:   bad = |{bus.in_funct2, bus.in_addr11,
                      bus.in_addr8};
      op_i:   bad = |{bus.in_rs2, bus.in_alu_type,
                      bus.in_addr11, bus.in_addr8};
      op_j:   bad = |{bus.in_rs1, bus.in_rs2,
                      bus.in_rd, bus.in_funct2,
                      bus.in_alu_type};
      op_b:   bad = |{bus.in_rd, bus.in_funct2,
                      bus.in_alu_type, bus.in_addr11}
                    || (bus.in_addr8[7] != bus.in_rs2[0]);
      op_ld:  bad = |{bus.in_rs1, bus.in_rs2,
                      bus.in_funct2, bus.in_alu_type,
                      bus.in_addr11};
      op_m:   bad = |{bus.in_rs2, bus.in_rd,
                      bus.in_funct2, bus.in_alu_type,
                      bus.in_addr11};
      op_ret: bad = |{bus.in_rs1, bus.in_rs2,
                      bus.in_rd, bus.in_funct2,
                      bus.in_alu_type, bus.in_addr11,
                      bus.in_addr8};
      default: bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      field_err <= 1'b0;
    else if (state == IDLE && start)
      field_err <= 1'b0;
    else if (in_fire && bad)
      field_err <= 1'b1;
  end
`else
  assign field_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized program loads against an arithmetic model of the encoding rules.
// Covers reset, throughput, stalls, overflow, field checks and mid-load reset.
module tb_instr_encoder;

  localparam int AW  = 11;
  localparam int TOP = (1 << AW) - 1;

  typedef struct {
    int op, rs1, rs2, rd;
    int f2, alu, a11, a8;
  } bnd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done, overflow, field_err;

  instr_encoder_if #(.AW(AW)) bus();

  instr_encoder #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .field_err (field_err)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  bnd_t bq[$];
  int   first_instr, first_addr, last_addr;
  int   words_seen;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  tag, got, exp);
  endtask

  function automatic bnd_t mk(int op, int rs1, int rs2,
                              int rd, int f2, int alu,
                              int a11, int a8);
    bnd_t b;
    b.op = op; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd;
    b.f2 = f2; b.alu = alu; b.a11 = a11; b.a8 = a8;
    return b;
  endfunction

  function automatic bnd_t rnd_bnd();
    return mk($urandom_range(15), $urandom_range(15),
              $urandom_range(15), $urandom_range(15),
              $urandom_range(3), $urandom_range(7),
              $urandom_range(2047), $urandom_range(255));
  endfunction

  function automatic int model_enc(bnd_t b);
    int w = b.op * 32768;
    if (b.op <= 1 || b.op >= 12)
      w += b.rs1*2048 + b.rs2*128 + b.rd*8 + b.alu;
    else if (b.op == 2)
      w += b.rs1*2048 + b.f2*512 + b.rd*8;
    else if (b.op == 3 || b.op == 7)
      w += b.a11;
    else if (b.op == 4)
      w += b.rs1*2048 + b.rs2*128 + (b.a8 % 128);
    else if (b.op == 5)
      w += b.rd*2048 + b.a8;
    else if (b.op == 8)
      w += 0;
    else
      w += b.rs1*2048 + b.a8;
    return w;
  endfunction

  function automatic bit model_ferr(bnd_t b);
`ifdef FIELD_CHECK_EN
    int spare;
    if (b.op <= 1 || b.op >= 12)
      spare = b.f2 + b.a11 + b.a8;
    else if (b.op == 2)
      spare = b.rs2 + b.alu + b.a11 + b.a8;
    else if (b.op == 3 || b.op == 7)
      spare = b.rs1 + b.rs2 + b.rd + b.f2 + b.alu;
    else if (b.op == 4)
      spare = b.rd + b.f2 + b.alu + b.a11
            + (((b.a8 / 128) != (b.rs2 % 2)) ? 1 : 0);
    else if (b.op == 5)
      spare = b.rs1 + b.rs2 + b.f2 + b.alu + b.a11;
    else if (b.op == 8)
      spare = b.rs1 + b.rs2 + b.rd + b.f2
            + b.alu + b.a11 + b.a8;
    else
      spare = b.rs2 + b.rd + b.f2 + b.alu + b.a11;
    return spare != 0;
`else
    return (b.op < 0);
`endif
  endfunction

  task automatic drive(input bnd_t b);
    bus.in_opcode   = 4'(b.op);
    bus.in_rs1      = 4'(b.rs1);
    bus.in_rs2      = 4'(b.rs2);
    bus.in_rd       = 4'(b.rd);
    bus.in_funct2   = 2'(b.f2);
    bus.in_alu_type = 3'(b.alu);
    bus.in_addr11   = 11'(b.a11);
    bus.in_addr8    = 8'(b.a8);
  endtask

  task automatic pulse_start(input int base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_load(input int base, input bit use_last,
                          input int vpct, input int rpct,
                          input bit stall);
    int n = bq.size();
    int idx = 0, ptr = base;
    bit ended = 0, ovf = 0, ferr = 0, seen = 0;
    int qa[$], qi[$];
    int first_acc = -1, last_acc = 0;
    bit hold = 0;
    int h_ins = 0, h_adr = 0;
    int budget = n * 30 + 60;
    int exp_acc = (n < TOP - base + 1) ? n : TOP - base + 1;
    words_seen = 0;
    first_instr = -1; first_addr = -1; last_addr = -1;
    pulse_start(base);
    for (int cyc = 0; cyc < budget; cyc++) begin
      bus.in_valid = !ended && idx < n
                   && ($urandom_range(99) < vpct);
      if (idx < n) drive(bq[idx]);
      bus.in_last  = use_last && (idx == n - 1);
      bus.out_ready = stall ? !(cyc >= 2 && cyc <= 4)
                            : ($urandom_range(99) < rpct);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
      if (hold) begin
        check("hold_instr", bus.out_instr, h_ins);
        check("hold_addr", bus.out_addr, h_adr);
      end
      check("in_ready", bus.in_ready,
            !ended && (!bus.out_valid || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (qa.size() == 0) begin
          check("spurious_word", 1, 0);
        end else begin
          check("out_addr", bus.out_addr, qa.pop_front());
          check("out_instr", bus.out_instr, qi.pop_front());
        end
        if (words_seen == 0) begin
          first_instr = bus.out_instr;
          first_addr  = bus.out_addr;
        end
        last_addr = bus.out_addr;
        words_seen++;
      end
      hold  = bus.out_valid && !bus.out_ready;
      h_ins = bus.out_instr;
      h_adr = bus.out_addr;
      if (bus.in_valid && bus.in_ready) begin
        qa.push_back(ptr);
        qi.push_back(model_enc(bq[idx]));
        if (model_ferr(bq[idx])) ferr = 1;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (bus.in_last) ended = 1;
        if (ptr == TOP) begin
          ended = 1;
          if (!bus.in_last) ovf = 1;
        end else begin
          ptr++;
        end
        idx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("done_seen", seen, 1);
    check("drained", qa.size(), 0);
    check("naccept", idx, exp_acc);
    check("overflow", overflow, ovf);
    check("field_err", field_err, ferr);
    if (vpct == 100 && rpct == 100 && !stall)
      check("no_bubble", last_acc - first_acc, idx - 1);
    @(negedge clk);
    #1;
    check("done_1cyc", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_field_err", field_err, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;

    // single R-type word
    bq = {};
    bq.push_back(mk(1, 3, 5, 7, 0, 2, 0, 0));
    run_load(16, 1, 100, 100, 0);
    check("t1_instr", first_instr, 32'h09ABA);
    check("t1_addr", first_addr, 32'h010);

    // back-to-back mixed formats
    bq = {};
    bq.push_back(mk(3, 0, 0, 0, 0, 0, 'h5A5, 0));
    bq.push_back(mk(5, 0, 0, 2, 0, 0, 0, 'h3C));
    bq.push_back(mk(8, 0, 0, 0, 0, 0, 0, 0));
    bq.push_back(mk(2, 1, 0, 4, 3, 0, 0, 0));
    run_load(32, 1, 100, 100, 0);
    check("t2_first", first_instr, 32'h185A5);
    check("t2_lastaddr", last_addr, 35);

    // downstream stall mid-stream
    bq = {};
    for (int i = 0; i < 6; i++) bq.push_back(rnd_bnd());
    run_load(100, 1, 100, 100, 1);
    check("t3_words", words_seen, 6);

    // address space exhaustion
    bq = {};
    for (int i = 0; i < 3; i++) bq.push_back(rnd_bnd());
    run_load(TOP - 1, 0, 100, 100, 0);
    check("t4_words", words_seen, 2);
    check("t4_lastaddr", last_addr, TOP);

    // branch with inconsistent address bit 7
    bq = {};
    bq.push_back(mk(4, 1, 4, 0, 0, 0, 0, 'h80));
    run_load(200, 1, 100, 100, 0);
    check("t5_instr", first_instr, 32'h20A00);

    // randomized loads with random handshakes
    for (int k = 0; k < 8; k++) begin
      int n = $urandom_range(3, 10);
      int b = (k == 7) ? TOP - 3 : $urandom_range(0, 1900);
      bq = {};
      for (int i = 0; i < n; i++) bq.push_back(rnd_bnd());
      run_load(b, 1, 70, 60, 0);
    end

    // reset while a word is pending
    bq = {};
    bq.push_back(rnd_bnd());
    pulse_start(300);
    drive(bq[0]);
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    begin
      bit got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        #1;
        if (bus.out_valid) got = 1;
        else @(negedge clk);
      end
      check("t6_pending", got, 1);
    end
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bq = {};
    for (int i = 0; i < 4; i++) bq.push_back(rnd_bnd());
    run_load(400, 1, 80, 80, 0);
    check("t6_words", words_seen, 4);
    check("t6_first_addr", first_addr, 400);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
